// File: rtl/pov_column_scheduler_if.sv
// Read bus between the column scheduler and its two synchronous-read memories
// (message buffer and font ROM).
interface pov_column_scheduler_if #(
  parameter int ADDR_W = 5,
  parameter int CODE_W = 6,
  parameter int LED_W  = 8
);
  logic [ADDR_W-1:0] msg_addr;
  logic [CODE_W-1:0] msg_char;
  logic [CODE_W+2:0] font_addr;
  logic [LED_W-1:0]  font_data;

  modport master (output msg_addr, font_addr, input msg_char, font_data);
  modport slave  (input msg_addr, font_addr, output msg_char, font_data);
endinterface

// File: rtl/pov_column_scheduler.sv
// POV column scheduler: measures rotation period from the hall index, divides each
// revolution into NCOLS slots and fetches char code then font column per slot.
module pov_column_scheduler #(
  parameter int NCOLS    = 128,
  parameter int PERIOD_W = 24,
  parameter int ADDR_W   = 5,
  parameter int CODE_W   = 6,
  parameter int CHAR_W   = 5,
  parameter int LED_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  index,
  input  logic [ADDR_W:0]       msg_len,
  pov_column_scheduler_if.master mem,
  output logic [LED_W-1:0]      leds,
  output logic                  rev_tick
);
  localparam int SLOT_W = $clog2(NCOLS);
  localparam int COL_W  = 3;
  localparam int CMP_W  = (SLOT_W > ADDR_W + 1) ? SLOT_W : ADDR_W + 1;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, WAIT_IDX, FETCH_CHAR, FETCH_FONT, SHOW} state_t;

  state_t              state;
  logic [2:0]          sync;
  logic                idx_pulse;
  logic [PERIOD_W-1:0] cnt, period_reg, timer;
  logic                period_valid;
  logic [SLOT_W-1:0]   slot, chr;
  logic [COL_W-1:0]    col;
  logic                load;

  logic [PERIOD_W-1:0] new_period, new_cp, load_cp;
  logic [SLOT_W-1:0]   nxt_slot, nxt_chr;
  logic [COL_W-1:0]    nxt_col;
  logic [ADDR_W:0]     len_eff;
  logic                idx_go, running, slot_end, last_slot, gap_now, nxt_blank;
  logic                start, stop;

  assign idx_pulse  = sync[1] & ~sync[2];
  assign new_period = cnt + PERIOD_W'(1);
  assign new_cp     = new_period >> SLOT_W;
  // A new revolution always uses the period measured by the pulse that starts it.
  assign load_cp    = idx_pulse ? new_cp : (period_reg >> SLOT_W);
  assign idx_go     = idx_pulse && period_valid && (new_cp >= PERIOD_W'(4));
  assign running    = state inside {FETCH_CHAR, FETCH_FONT, SHOW};
  assign slot_end   = (state == SHOW) && (timer == '0);
  assign last_slot  = (slot == SLOT_W'(NCOLS - 1));
  assign gap_now    = (col == COL_W'(CHAR_W));

  assign nxt_slot  = idx_pulse ? '0 : slot + SLOT_W'(1);
  assign nxt_col   = (idx_pulse || gap_now) ? '0 : col + COL_W'(1);
  assign nxt_chr   = idx_pulse ? '0 : (gap_now ? chr + SLOT_W'(1) : chr);
  assign len_eff   = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
  assign nxt_blank = (nxt_col == COL_W'(CHAR_W)) || (CMP_W'(nxt_chr) >= CMP_W'(len_eff));

  assign start = enable && ((idx_go && (state == WAIT_IDX || running)) ||
                            (slot_end && !idx_pulse && !last_slot));
  assign stop  = enable && running && ((idx_pulse && !idx_go) ||
                                       (slot_end && !idx_pulse && last_slot));

  // Font address follows msg_char directly so the font read lands in slot cycle 1.
  assign mem.font_addr = (state == FETCH_FONT) ? {mem.msg_char, col} : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync         <= '0;
      cnt          <= '0;
      period_reg   <= '0;
      period_valid <= 1'b0;
      state        <= IDLE;
      slot         <= '0;
      chr          <= '0;
      col          <= '0;
      timer        <= '0;
      load         <= 1'b0;
      mem.msg_addr <= '0;
      leds         <= '0;
      rev_tick     <= 1'b0;
    end else begin
      sync     <= {sync[1:0], index};
      rev_tick <= idx_pulse;

      if (idx_pulse) begin
        cnt          <= '0;
        period_reg   <= new_period;
        period_valid <= 1'b1;
      end else if (cnt == '1) begin
        period_valid <= 1'b0;
      end else begin
        cnt <= new_period;
      end

      load <= 1'b0;
      if (running) timer <= timer - PERIOD_W'(1);

      case (state)
        IDLE:       if (enable) state <= WAIT_IDX;
        FETCH_CHAR: state <= FETCH_FONT;
        FETCH_FONT: begin
          state <= SHOW;
          load  <= 1'b1;
        end
        SHOW:       if (load) leds <= mem.font_data;
        default:    ;
      endcase

      // Gap and out-of-message slots skip the fetch and go dark for the whole slot.
      if (start) begin
        slot  <= nxt_slot;
        chr   <= nxt_chr;
        col   <= nxt_col;
        timer <= load_cp - PERIOD_W'(1);
        load  <= 1'b0;
        if (nxt_blank) begin
          state <= SHOW;
          leds  <= '0;
        end else begin
          state        <= FETCH_CHAR;
          mem.msg_addr <= ADDR_W'(nxt_chr);
        end
      end

      if (stop) begin
        state <= WAIT_IDX;
        leds  <= '0;
      end

      if (!enable) begin
        state <= IDLE;
        leds  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pov_column_scheduler.sv
// Directed bench for pov_column_scheduler, scaled to NCOLS=16 / PERIOD_W=12 so that
// period saturation is reachable in a short run.
module tb_pov_column_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       index = 1'b0;
  logic [5:0] msg_len = '0;
  logic [7:0] leds;
  logic       rev_tick;

  logic [5:0] msg_mem [32];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  pov_column_scheduler_if #(.ADDR_W(5), .CODE_W(6), .LED_W(8)) mem_bus ();

  pov_column_scheduler #(
    .NCOLS(16), .PERIOD_W(12), .ADDR_W(5), .CODE_W(6), .CHAR_W(5), .LED_W(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .index(index),
    .msg_len(msg_len), .mem(mem_bus), .leds(leds), .rev_tick(rev_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] font_fn(input logic [8:0] a);
    return a[7:0] ^ 8'hC3;
  endfunction

  function automatic logic [7:0] glyph(input logic [5:0] code, input logic [2:0] c);
    return font_fn({code, c});
  endfunction

  always @(posedge clk) begin
    mem_bus.msg_char  <= msg_mem[mem_bus.msg_addr];
    mem_bus.font_data <= font_fn(mem_bus.font_addr);
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle raw index pulse raised after edge t; the DUT acts on it at edge t+3.
  task automatic idx_at(input int t);
    goto(t);
    index = 1'b1;
    goto(t + 1);
    index = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_led;
    logic [4:0] exp_addr;
    for (int i = 0; i < 32; i++) msg_mem[i] = 6'h3F;
    msg_mem[0] = 6'h0A;
    msg_mem[1] = 6'h0B;
    msg_mem[2] = 6'h15;

    goto(2);
    chk("reset_leds", leds, 0);
    chk("reset_msg_addr", mem_bus.msg_addr, 0);
    chk("reset_font_addr", mem_bus.font_addr, 0);
    chk("reset_rev_tick", rev_tick, 0);
    reset   = 1'b0;
    enable  = 1'b1;
    msg_len = 6'd2;

    // First index only validates the period: revolution 1 stays dark.
    idx_at(10);
    goto(13);  chk("tick_first", rev_tick, 1);
    goto(14);  chk("tick_clear", rev_tick, 0);
    goto(800); chk("rev1_blank", leds, 0);

    // Revolution 2, period 1600 -> col_period 100.
    idx_at(1610);
    goto(1613); chk("start_msg_addr", mem_bus.msg_addr, 0);
    goto(1614); chk("start_font_addr", mem_bus.font_addr, 9'h050);
    goto(1615); chk("leds_not_early", leds, 0);
    goto(1616); chk("leds_latency3", leds, glyph(6'h0A, 3'd0));
    for (int n = 0; n < 16; n++) begin
      goto(1663 + 100 * n);
      if (n % 6 == 5 || n / 6 >= 2) exp_led = 8'h00;
      else exp_led = glyph(msg_mem[n / 6], 3'(n % 6));
      exp_addr = (n < 6) ? 5'd0 : 5'd1;
      chk("slot_leds", leds, exp_led);
      chk("slot_msg_addr", mem_bus.msg_addr, exp_addr);
    end

    // Revolution 3 with msg_len 33, clamped to 32: slots 12-15 show char 2.
    idx_at(3210);
    goto(3220); msg_len = 6'd33;
    goto(4463); chk("clamp_leds", leds, glyph(6'h15, 3'd0));
    chk("clamp_msg_addr", mem_bus.msg_addr, 2);
    goto(4763); chk("last_slot_leds", leds, glyph(6'h15, 3'd3));
    goto(4812); chk("last_slot_hold", leds, glyph(6'h15, 3'd3));
    goto(4814); chk("wait_idx_dark", leds, 0);
    goto(4850); chk("wait_idx_dark2", leds, 0);

    // Period 1690 -> col_period 105; early index during slot 7 resyncs.
    idx_at(4900);
    idx_at(5675);
    goto(5677); chk("pre_abort_leds", leds, glyph(6'h0B, 3'd1));
    chk("pre_abort_addr", mem_bus.msg_addr, 1);
    goto(5678); chk("abort_restart_addr", mem_bus.msg_addr, 0);
    goto(5681); chk("abort_slot0_leds", leds, glyph(6'h0A, 3'd0));
    // New period 775 -> col_period 48: slot 6 fetch starts at edge 5678+288.
    goto(5965); chk("new_cp_before", mem_bus.msg_addr, 0);
    goto(5966); chk("new_cp_at", mem_bus.msg_addr, 1);

    goto(6100); chk("pre_disable_leds", leds, glyph(6'h0B, 3'd2));
    enable = 1'b0;
    goto(6101); chk("disable_dark", leds, 0);
    goto(6110); enable = 1'b1;
    goto(6550); chk("reenable_waits", leds, 0);
    idx_at(6597);
    goto(6599); chk("reenable_addr_hold", mem_bus.msg_addr, 1);
    goto(6600); chk("reenable_start_addr", mem_bus.msg_addr, 0);
    goto(6602); chk("reenable_not_early", leds, 0);
    goto(6603); chk("reenable_leds", leds, glyph(6'h0A, 3'd0));

    // No index for >4095 cycles: the next edge must not start the display.
    idx_at(10997);
    goto(11003); chk("sat_no_display", leds, 0);
    goto(11010); chk("sat_addr_hold", mem_bus.msg_addr, 2);
    idx_at(12597);
    goto(12601); chk("sat_resume_addr", mem_bus.msg_addr, 0);
    goto(12602); chk("sat_resume_early", leds, 0);
    goto(12603); chk("sat_resume_leds", leds, glyph(6'h0A, 3'd0));

    // col_period 3 is rejected, 4 is accepted.
    idx_at(12997);
    idx_at(13045);
    goto(13047); chk("fast_pre_leds", leds, glyph(6'h0A, 3'd1));
    goto(13048); chk("fast_tick", rev_tick, 1);
    goto(13049); chk("cp3_dark", leds, 0);
    chk("fast_tick_clear", rev_tick, 0);
    idx_at(13093);
    goto(13096); chk("cp3_tick", rev_tick, 1);
    goto(13099); chk("cp3_still_dark", leds, 0);
    chk("cp3_addr_hold", mem_bus.msg_addr, 0);
    idx_at(13141);
    idx_at(13205);
    goto(13210); chk("cp4_early", leds, 0);
    goto(13211); chk("cp4_leds", leds, glyph(6'h0A, 3'd0));

    goto(13300); enable = 1'b0;
    idx_at(13397);
    goto(13400); chk("tick_disabled", rev_tick, 1);
    goto(13401); chk("disabled_dark", leds, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
